// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async-FIFO write port.
// Admits a burst only when the FIFO can absorb MAX_BURST words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_BURST  = 16
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  input  logic [ADDR_WIDTH:0]           wptr,
  input  logic [ADDR_WIDTH:0]           wq2_rptr,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [ADDR_WIDTH:0]           free_cnt
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;
  localparam logic [PW-1:0] MAXB  = PW'(MAX_BURST);
  localparam logic [BW-1:0] LASTB = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   rr_last;
  logic [GW-1:0]   sel;
  logic [GW-1:0]   cand;
  logic            found;
  logic [BW-1:0]   beat_cnt;
  logic [PW-1:0]   wbin, rbin, used;
  logic            xfer, burst_end;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // modular difference stays correct across the pointer MSB wrap
  assign wbin     = g2b(wptr);
  assign rbin     = g2b(wq2_rptr);
  assign used     = wbin - rbin;
  assign free_cnt = DEPTH - used;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(rr_last) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign busy      = (state == BURST);
  assign xfer      = busy && req_valid[grant_id] && !wfull;
  assign burst_end = xfer &&
                     (req_last[grant_id] || beat_cnt == LASTB);
  assign wdata     = data_arr[grant_id];

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    winc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && free_cnt >= MAXB)
          state_nx = BURST;
      end
      BURST: begin
        req_ready[grant_id] = !wfull;
        winc                = xfer;
        if (burst_end)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_last  <= GW'(NUM_REQ - 1);
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == BURST) begin
        grant_id <= sel;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
      if (burst_end)
        rr_last <= grant_id;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a packet-level round-robin
// model predicts the FIFO write stream; a monitor checks each write.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
    logic       eob;
  } exp_t;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        wfull;
  logic [9:0]  wptr;
  logic [9:0]  wq2_rptr;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic [9:0]  free_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wbase = 0;
  int wcount = 0;
  int rbin  = 0;
  int wr_total = 0;
  int mrr   = N - 1;
  bit gap_en = 0;
  bit stall_en = 0;
  bit full_rand = 0;
  bit full_hold = 0;
  bit pend_chk = 0;
  bit pend_eob = 0;

  beat_t src_q [N][$];
  beat_t mq    [N][$];
  exp_t  exp_q [$];
  int    wc_q  [$];

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(8), .ADDR_WIDTH(9), .MAX_BURST(MB)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr),
    .winc(winc), .wdata(wdata), .grant_id(grant_id),
    .busy(busy), .free_cnt(free_cnt)
  );

  always #5 wclk = ~wclk;

  function automatic logic [9:0] gray10(input int b);
    logic [9:0] v;
    v = b[9:0];
    return v ^ (v >> 1);
  endfunction

  assign wptr     = gray10(wbase + wcount);
  assign wq2_rptr = gray10(rbin);
  assign wfull    = full_rand | full_hold |
                    (((wbase + wcount - rbin) & 1023) >= 512);

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // FIFO pointer model and requester sources
  always @(posedge wclk) begin
    cyc++;
    if (wrst_n && winc) wcount++;
    for (int i = 0; i < N; i++)
      if (wrst_n && req_valid[i[1:0]] && req_ready[i[1:0]] &&
          src_q[i].size() > 0)
        void'(src_q[i].pop_front());
    #1;
    begin
      logic [3:0]  v, l;
      logic [31:0] d;
      bit gap;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < N; i++) begin
        gap = gap_en && busy && (int'(grant_id) == i) &&
              ($urandom_range(0, 3) == 0);
        if (src_q[i].size() > 0 && !gap) begin
          v |= 4'(1) << i;
          l |= 4'(src_q[i][0].last) << i;
          d |= 32'(src_q[i][0].d) << (8 * i);
        end
      end
      req_valid = v;
      req_last  = l;
      req_data  = d;
      full_rand = stall_en && ($urandom_range(0, 4) == 0);
    end
  end

  // monitor
  always @(negedge wclk) begin
    if (!wrst_n) begin
      pend_chk = 0;
    end else begin
      logic [3:0] er;
      exp_t e;
      if (pend_chk) begin
        chk(busy == !pend_eob, "burst_end", busy, !pend_eob);
        pend_chk = 0;
      end
      er = (busy && !wfull) ? (4'(1) << grant_id) : 4'b0;
      chk(req_ready == er, "req_ready", req_ready, er);
      if (winc) begin
        chk(!wfull, "write_full", wfull, 0);
        wc_q.push_back(cyc);
        wr_total++;
        if (exp_q.size() == 0) begin
          chk(0, "extra_write", wdata, -1);
        end else begin
          e = exp_q.pop_front();
          chk(grant_id == e.id, "wr_owner", grant_id, e.id);
          chk(wdata == e.d, "wr_data", wdata, e.d);
          pend_chk = 1;
          pend_eob = e.eob;
        end
      end
    end
  end

  task automatic add_pkt(input int i, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d    = 8'($urandom);
      b.last = (k == len - 1);
      src_q[i].push_back(b);
      mq[i].push_back(b);
    end
  endtask

  // packet-level round robin: whole bursts, capped at MB beats
  task automatic model_run();
    int i, n;
    bit go;
    beat_t b;
    exp_t e;
    go = 1;
    while (go) begin
      go = 0;
      for (int k = 1; k <= N; k++) begin
        i = (mrr + k) % N;
        if (!go && mq[i].size() > 0) begin
          n = 0;
          do begin
            b = mq[i].pop_front();
            n++;
            e.id  = 2'(i);
            e.d   = b.d;
            e.eob = b.last || (n == MB);
            exp_q.push_back(e);
          end while (!e.eob && mq[i].size() > 0);
          mrr = i;
          go  = 1;
        end
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < 3000) begin
      @(posedge wclk);
      n++;
    end
    chk(n < 3000, nm, exp_q.size(), 0);
    repeat (2) @(negedge wclk);
  endtask

  task automatic wait_beats(input int cnt, input string nm);
    int tgt = wr_total + cnt;
    int n = 0;
    while (wr_total < tgt && n < 500) begin
      @(negedge wclk);
      n++;
    end
    chk(wr_total >= tgt, nm, wr_total, tgt);
  endtask

  task automatic drain();
    @(negedge wclk);
    rbin = wbase + wcount;
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge wclk);
    chk(req_ready == 0, "rst_ready", req_ready, 0);
    chk(winc == 0, "rst_winc", winc, 0);
    chk(busy == 0, "rst_busy", busy, 0);
    chk(grant_id == 0, "rst_grant", grant_id, 0);
    chk(free_cnt == 512, "rst_free", free_cnt, 512);
    wrst_n = 1'b1;

    // all four requesters, single-beat packets
    add_pkt(0, 1); add_pkt(0, 1);
    add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1);
    model_run();
    wc_q.delete();
    wait_idle("t1_done");
    chk(wc_q.size() == 5, "t1_count", wc_q.size(), 5);
    for (int k = 0; k + 1 < wc_q.size(); k++)
      chk(wc_q[k+1] - wc_q[k] == 2, "t1_spacing",
          wc_q[k+1] - wc_q[k], 2);

    // long packet split into capped bursts, others interleave
    add_pkt(2, 40); add_pkt(0, 20); add_pkt(3, 5);
    model_run();
    wait_idle("t2_done");

    // insufficient space: no grant until 6 more words free
    drain();
    wbase = rbin + 502 - wcount;
    @(negedge wclk);
    chk(free_cnt == 10, "t3_free", free_cnt, 10);
    add_pkt(1, 5);
    model_run();
    repeat (6) begin
      @(negedge wclk);
      chk(!busy && !winc, "t3_hold", busy, 0);
    end
    rbin = rbin + 6;
    @(negedge wclk);
    chk(busy == 1, "t3_grant", busy, 1);
    wait_idle("t3_done");

    // wfull held for 3 cycles mid-burst
    drain();
    add_pkt(1, 12);
    model_run();
    wait_beats(3, "t4_start");
    @(posedge wclk); #1;
    full_hold = 1;
    repeat (3) begin
      @(negedge wclk);
      chk(winc == 0 && req_ready == 0, "t4_stall", winc, 0);
    end
    @(posedge wclk); #1;
    full_hold = 0;
    wait_idle("t4_done");

    // wrapped pointers, FIFO exactly full
    drain();
    rbin  = 515;
    wbase = 1027 - wcount;
    @(negedge wclk);
    chk(free_cnt == 0, "t5_free0", free_cnt, 0);
    add_pkt(0, 3);
    model_run();
    repeat (5) begin
      @(negedge wclk);
      chk(!busy && !winc, "t5_hold", busy, 0);
    end
    rbin  = 1000;
    wbase = 1034 - wcount;
    #1;
    chk(free_cnt == 478, "t5_free_wrap", free_cnt, 478);
    wait_idle("t5_done");

    // randomized traffic with valid gaps and wfull stalls
    gap_en   = 1;
    stall_en = 1;
    for (int r = 0; r < 6; r++) begin
      drain();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) != 0)
          for (int p = 0; p < $urandom_range(1, 3); p++)
            add_pkt(i, $urandom_range(1, 40));
      model_run();
      wait_idle("rand_done");
    end
    gap_en   = 0;
    stall_en = 0;
    full_rand = 0;

    // reset on beat 5 of a burst
    drain();
    add_pkt(2, 30);
    model_run();
    wait_beats(4, "t6_start");
    @(posedge wclk); #1;
    wrst_n = 1'b0;
    #1;
    chk(winc == 0 && req_ready == 0, "t6_rst_out", winc, 0);
    chk(busy == 0 && grant_id == 0, "t6_rst_state", busy, 0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    mrr = N - 1;
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
    add_pkt(3, 2); add_pkt(0, 2);
    model_run();
    wait_idle("t6_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
